sum_lshift_stage: RTL and testbench
===================================

Name: sum_lshift_stage

Overview:
- Downstream stage of the 4-bit ripple-carry adder.
- Accepts the adder's 5-bit sum over a valid/ready handshake, together with a shift amount.
- Performs a variable logical left shift iteratively, one bit per cycle, into an OUT_W-bit result.
- Flags overflow when any 1 bit is shifted out, then presents the result on a valid/ready output.

Parameters:
- IN_W, 5, width of incoming sum (adder output width).
- OUT_W, 8, width of shifted result; must be >= IN_W.
- SHW, 3, width of shift-amount input; max shift 2^SHW-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream sum and shift amount valid.
- in_ready  output  1  stage can accept an operand.
- in_sum  input  IN_W  sum from adder, unsigned.
- in_shamt  input  SHW  left-shift amount, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  OUT_W  shifted result, truncated to OUT_W bits.
- out_ovf  output  1  set if any 1 bit was shifted out past bit OUT_W-1.

Behaviour:
- Reset is asynchronous and active-low; the clock is clk, the reset is rst_n.
- On reset:
  - state=IDLE; internal accumulator=0; counter=0; ovf=0.
  - out_valid=0, out_data=0, out_ovf=0, in_ready=1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready at edge T:
    - acc <= zero-extended in_sum.
    - cnt <= in_shamt; ovf <= 0.
    - Next state is DONE if in_shamt==0, else SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each edge: acc <= {acc[OUT_W-2:0],0}; ovf <= ovf | acc[OUT_W-1]; cnt <= cnt-1.
  - When cnt==1 at the edge, next state is DONE.
- DONE:
  - out_valid=1; out_data=acc; out_ovf=ovf; in_ready=0.
  - out_data and out_ovf are held stable while out_ready=0.
  - On out_valid & out_ready: next state IDLE.
  - No new input is accepted in the same cycle; in_ready rises the following cycle.
- Latency: input accepted at edge T gives out_valid high from edge T+1+in_shamt.
- Throughput: at most one result per in_shamt+2 cycles.
- in_sum and in_shamt are sampled only at the accepting edge; later changes have no effect.
- Result arithmetic: out_data = (in_sum << in_shamt) mod 2^OUT_W; out_ovf = ((in_sum << in_shamt) >> OUT_W) != 0.
- in_shamt >= OUT_W (possible when 2^SHW-1 >= OUT_W): out_data=0, out_ovf=(in_sum!=0).
- in_valid while busy: ignored (in_ready=0). Upstream must hold it until accepted.
- Reset mid-operation (SHIFT or DONE):
  - Immediate return to IDLE; out_valid drops asynchronously.
  - The result in flight is discarded.
- out_valid never deasserts without a handshake except on reset.

Optional Feature:
- Macro: SUM_LSHIFT_BARREL_EN.
- Defined:
  - SHIFT state is unused.
  - At the accepting edge, acc <= (in_sum << in_shamt) truncated, and ovf is computed combinationally from the discarded bits.
  - Next state is always DONE, so out_valid is high from T+1 for every shift amount.
  - Throughput is one result per 2 cycles.
- Undefined: iterative one-bit-per-cycle behaviour as above.
- Result values and handshake rules are identical in both builds.

Test Plan:
- in_sum=5'h13, in_shamt=2, accepted at T, out_ready=1 -> out_valid at T+3, out_data=8'h4C, out_ovf=0, in_ready high again at T+4.
- in_sum=5'h1F, in_shamt=3 -> out_data=8'hF8, out_ovf=0; then in_sum=5'h1F, in_shamt=4 -> out_data=8'hF0, out_ovf=1.
- in_sum=5'h1F, in_shamt=7 -> out_data=8'h80, out_ovf=1, out_valid at T+8 (T+1 with SUM_LSHIFT_BARREL_EN).
- in_sum=5'h10, in_shamt=0 -> out_valid at T+1, out_data=8'h10, out_ovf=0.
- Backpressure, in_sum=5'h05, in_shamt=1:
  - Hold out_ready=0 for 5 cycles after out_valid -> out_data=8'h0A stable, in_ready=0 throughout, in_valid ignored.
  - Then out_ready=1 -> handshake, in_ready=1 next cycle.
- in_sum=5'h1F, in_shamt=6, with rst_n pulsed low two cycles after acceptance -> out_valid=0 and in_ready=1 immediately after reset; the next operand (in_sum=5'h01, in_shamt=1) yields out_data=8'h02, out_ovf=0.

Source files
------------

// File: rtl/sum_lshift_stage.sv
// rtl/sum_lshift_stage.sv - left-shift stage behind the 4-bit adder, valid/ready in and out
// Optional macro SUM_LSHIFT_BARREL_EN: single-cycle barrel shift replaces the one-bit-per-cycle loop.
module sum_lshift_stage #(
   parameter int IN_W  = 5,
   parameter int OUT_W = 8,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_sum,
   input  logic [SHW-1:0]   in_shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;

`ifdef SUM_LSHIFT_BARREL_EN
   // Wide enough to hold the operand after the largest possible shift, so every
   // bit pushed past OUT_W-1 is still visible for the overflow flag.
   localparam int WIDE_W = OUT_W + (1 << SHW);
   logic [WIDE_W-1:0] wide;
`else
   logic [SHW-1:0]    cnt_q, cnt_d;
`endif

   // State register; reset returns to IDLE at once, dropping any result in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: accumulator, overflow sticky bit and remaining-shift counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
`ifndef SUM_LSHIFT_BARREL_EN
         cnt_q <= '0;
`endif
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
`ifndef SUM_LSHIFT_BARREL_EN
         cnt_q <= cnt_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef SUM_LSHIFT_BARREL_EN
               state_d = DONE;
`else
               state_d = (in_shamt == '0) ? DONE : SHIFT;
`endif
            end
         end
         SHIFT: begin
`ifdef SUM_LSHIFT_BARREL_EN
            state_d = IDLE;
`else
            if (cnt_q == SHW'(1)) begin
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: load on acceptance, shift one bit per SHIFT cycle, hold otherwise
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
`ifdef SUM_LSHIFT_BARREL_EN
      wide  = WIDE_W'(in_sum) << in_shamt;
`else
      cnt_d = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef SUM_LSHIFT_BARREL_EN
               acc_d = wide[OUT_W-1:0];
               ovf_d = |wide[WIDE_W-1:OUT_W];
`else
               acc_d = OUT_W'(in_sum);
               ovf_d = 1'b0;
               cnt_d = in_shamt;
`endif
            end
         end
`ifndef SUM_LSHIFT_BARREL_EN
         SHIFT: begin
            acc_d = {acc_q[OUT_W-2:0], 1'b0};
            ovf_d = ovf_q | acc_q[OUT_W-1];
            cnt_d = cnt_q - SHW'(1);
         end
`endif
         default: ;
      endcase
   end

   // Handshake outputs decoded from state; the result is only presented in DONE
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      out_data  = (state_q == DONE) ? acc_q : '0;
      out_ovf   = (state_q == DONE) ? ovf_q : 1'b0;
   end

endmodule

// File: tb/tb_sum_lshift_stage.sv
// tb/tb_sum_lshift_stage.sv - self-checking bench for sum_lshift_stage
module tb_sum_lshift_stage;

`ifdef SUM_LSHIFT_BARREL_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [4:0] in_sum = '0;
   logic [2:0] in_shamt = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_ovf;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] data;
      logic       ovf;
      int         first;
   } exp_t;
   exp_t q[$];

   sum_lshift_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_shamt  (in_shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a queue of pending results computed with plain arithmetic,
   // checked against the DUT on every falling edge outside reset.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         chk("in_ready", in_ready, q.size() == 0);
         chk("out_valid", out_valid, (q.size() != 0) && (cyc >= q[0].first));
         if (out_valid && q.size() != 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_ovf", out_ovf, q[0].ovf);
         end
         if (out_valid && out_ready && q.size() != 0) q.pop_front();
         if (in_valid && in_ready) begin
            exp_t e;
            int unsigned full;
            full = int'(in_sum) << in_shamt;
            e.data = full[7:0];
            e.ovf = (full >> 8) != 0;
            e.first = cyc + 1 + (BARREL ? 0 : int'(in_shamt));
            q.push_back(e);
         end
      end
   end

   // Send one operand, wait for its result, optionally stall the output, then complete the handshake.
   task automatic op(input logic [4:0] s, input logic [2:0] sh, input bit lit,
                     input logic [7:0] ld, input logic lo, input int llat, input int hold);
      int n;
      int lat;
      in_sum = s;
      in_shamt = sh;
      in_valid = 1'b1;
      out_ready = (hold == 0);
      n = 0;
      while (!in_ready) begin
         @(posedge clk); #1;
         n++;
         if (n > 100) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sum = 5'($urandom);
      in_shamt = 3'($urandom);
      lat = 1;
      while (!out_valid) begin
         @(posedge clk); #1;
         lat++;
         if (lat > 100) begin
            chk("result_timeout", 0, 1);
            return;
         end
      end
      if (lit) begin
         chk("lit_latency", lat, llat);
         chk("lit_data", out_data, ld);
         chk("lit_ovf", out_ovf, lo);
      end
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_sum = 5'($urandom);
         in_shamt = 3'($urandom);
         @(posedge clk); #1;
         if (lit) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_data", out_data, ld);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      if (lit) begin
         chk("post_hs_in_ready", in_ready, 1);
         chk("post_hs_out_valid", out_valid, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      op(5'h13, 3'd2, 1'b1, 8'h4C, 1'b0, BARREL ? 1 : 3, 0);
      op(5'h1F, 3'd3, 1'b1, 8'hF8, 1'b0, BARREL ? 1 : 4, 0);
      op(5'h1F, 3'd4, 1'b1, 8'hF0, 1'b1, BARREL ? 1 : 5, 0);
      op(5'h1F, 3'd7, 1'b1, 8'h80, 1'b1, BARREL ? 1 : 8, 0);
      op(5'h10, 3'd0, 1'b1, 8'h10, 1'b0, 1, 0);
      op(5'h05, 3'd1, 1'b1, 8'h0A, 1'b0, BARREL ? 1 : 2, 5);

      // Reset two cycles after acceptance of a long shift
      in_sum = 5'h1F;
      in_shamt = 3'd6;
      in_valid = 1'b1;
      out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      op(5'h01, 3'd1, 1'b1, 8'h02, 1'b0, BARREL ? 1 : 2, 0);

      // Reset while a result is waiting in DONE under backpressure
      in_sum = 5'h0F;
      in_shamt = 3'd0;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("done_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("donerst_out_valid", out_valid, 0);
      chk("donerst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 40; k++) begin
         op(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1'b0, 8'h00, 1'b0, 0,
            $urandom_range(0, 3));
      end

      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
